// File: rtl/regfile_writeback_ctrl_pkg.sv
// Shared types and constants for the register-file writeback path.
package regfile_writeback_ctrl_pkg;
    localparam int WB_XLEN = 32;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    typedef struct packed {
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_ctrl_wb_fifo.sv
// Small synchronous FIFO of extracted load responses waiting for the write port.
module wb_fifo
    import regfile_writeback_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  wb_entry_t     wr_entry,
    output wb_entry_t     head,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Register-file write port: arbitrates ALU results against buffered load responses
// and tracks outstanding load destinations for decode hazard checks.
module regfile_writeback_ctrl
    import regfile_writeback_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_stall,
    input  logic            ld_issue_valid,
    input  logic [4:0]      ld_issue_rd,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_offset,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            wen,
    output logic [4:0]      waddr,
    output logic [XLEN-1:0] wdata
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]      byte_lane;
    logic [15:0]     half_lane;
    logic [XLEN-1:0] ld_ext;
    wb_entry_t       push_entry;
    wb_entry_t       head;
    logic [CW-1:0]   count;
    logic            full;
    logic            push;
    logic            pop;
    logic            sel_valid;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [31:0]     busy;
    logic [31:0]     busy_nxt;

    // Misaligned halfword (offset 3) just takes the upper half.
    assign byte_lane = ld_data[{ld_offset, 3'b000} +: 8];
    assign half_lane = ld_data[{ld_offset[1], 4'b0000} +: 16];

    always_comb begin
        ld_ext = ld_data;
        case (ld_funct3)
            LOAD_LB:  ld_ext = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            LOAD_LH:  ld_ext = {{(XLEN-16){half_lane[15]}}, half_lane};
            LOAD_LW:  ld_ext = ld_data;
            LOAD_LBU: ld_ext = {{(XLEN-8){1'b0}}, byte_lane};
            LOAD_LHU: ld_ext = {{(XLEN-16){1'b0}}, half_lane};
            default:  ld_ext = ld_data;
        endcase
    end

    assign push_entry = '{rd: ld_rd, data: ld_ext};
    assign full       = (count == CW'(DEPTH));
    assign ld_ready   = !full;
    assign push       = ld_valid && ld_ready;
    assign alu_stall  = full;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .wr_entry (push_entry),
        .head     (head),
        .count    (count)
    );

    // A full FIFO takes priority so load responses can never deadlock behind ALU traffic.
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = REG_X0;
        sel_data  = '0;
        pop       = 1'b0;
        if (full) begin
            pop       = 1'b1;
            sel_valid = 1'b1;
            sel_rd    = head.rd;
            sel_data  = head.data;
        end else if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end else if (count != '0) begin
            pop       = 1'b1;
            sel_valid = 1'b1;
            sel_rd    = head.rd;
            sel_data  = head.data;
        end
    end

    always_comb begin
        busy_nxt = busy;
        if (pop) busy_nxt[head.rd] = 1'b0;
        if (ld_issue_valid && ld_issue_rd != REG_X0) busy_nxt[ld_issue_rd] = 1'b1;
    end

    assign rs1_busy = busy[rs1];
    assign rs2_busy = busy[rs2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            wen   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            busy  <= busy_nxt;
            wen   <= sel_valid && (sel_rd != REG_X0);
            waddr <= sel_rd;
            wdata <= sel_data;
        end
    end
endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Directed plus random bench for regfile_writeback_ctrl against a queue-based model.
module tb_regfile_writeback_ctrl;
    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_stall;
    logic            ld_issue_valid;
    logic [4:0]      ld_issue_rd;
    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic [2:0]      ld_funct3;
    logic [1:0]      ld_offset;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            wen;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;

    regfile_writeback_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .ld_funct3(ld_funct3), .ld_offset(ld_offset),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wen(wen), .waddr(waddr), .wdata(wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    bit          busy_m [32];
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load extraction straight from the ISA definition, using shifts and masks.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off);
        int unsigned b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        exp_wen = 1'b0; exp_waddr = '0; exp_wdata = '0;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0; ld_issue_valid = 0; ld_issue_rd = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0; ld_funct3 = 0; ld_offset = 0;
    endtask

    // One clock: check registered outputs, drive inputs, check comb outputs, step model.
    task automatic cyc(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                       input bit iv, input logic [4:0] ird,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic [2:0] f3, input logic [1:0] off,
                       input logic [4:0] r1, input logic [4:0] r2);
        bit          full, sel, popm;
        logic [4:0]  srd;
        logic [31:0] sdat;
        ent_t        e;
        @(negedge clk);
        chk("wen", wen, exp_wen);
        if (exp_wen) begin
            chk("waddr", waddr, exp_waddr);
            chk("wdata", wdata, exp_wdata);
        end
        alu_valid = av; alu_rd = ard; alu_data = adat;
        ld_issue_valid = iv; ld_issue_rd = ird;
        ld_valid = lv; ld_rd = lrd; ld_data = ldat; ld_funct3 = f3; ld_offset = off;
        rs1 = r1; rs2 = r2;
        #1;
        full = (q.size() == DEPTH);
        chk("ld_ready", ld_ready, !full);
        if (av) chk("alu_stall", alu_stall, full);
        chk("rs1_busy", rs1_busy, busy_m[r1]);
        chk("rs2_busy", rs2_busy, busy_m[r2]);
        sel = 0; popm = 0; srd = 0; sdat = 0;
        if (full || (!av && q.size() > 0)) begin
            popm = 1; sel = 1; srd = q[0].rd; sdat = q[0].data;
        end else if (av) begin
            sel = 1; srd = ard; sdat = adat;
        end
        if (popm) begin
            busy_m[q[0].rd] = 1'b0;
            void'(q.pop_front());
        end
        if (iv && ird != 0) busy_m[ird] = 1'b1;
        if (lv && !full) begin
            e.rd = lrd; e.data = extract(ldat, f3, off);
            q.push_back(e);
        end
        exp_wen = sel && (srd != 0); exp_waddr = srd; exp_wdata = sdat;
    endtask

    task automatic idle_cyc(input logic [4:0] r1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        rs1 = 9; rs2 = 7;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_wen", wen, 0);
        chk("reset_ld_ready", ld_ready, 1);
        chk("reset_alu_stall", alu_stall, 0);
        chk("reset_rs1_busy", rs1_busy, 0);
        chk("reset_rs2_busy", rs2_busy, 0);
        rst_n = 1'b1;

        // ALU write appears one cycle later, then drops.
        cyc(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_cyc(0);
        chk("alu_wen", wen, 1);
        chk("alu_waddr", waddr, 5);
        chk("alu_wdata", wdata, 32'h1234);
        idle_cyc(0);
        chk("alu_wen_drop", wen, 0);

        // LB with busy tracking on rd 7.
        cyc(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 7, 0);
        cyc(0, 0, 0, 0, 0, 1, 7, 32'h0000_80FF, 3'b000, 2'd1, 7, 0);
        chk("lb_busy_pending", rs1_busy, 1);
        idle_cyc(7);
        chk("lb_busy_pop_cycle", rs1_busy, 1);
        idle_cyc(7);
        chk("lb_busy_cleared", rs1_busy, 0);
        chk("lb_wdata", wdata, 32'hFFFF_FF80);
        chk("lb_waddr", waddr, 7);

        // LHU then LH of the same word.
        cyc(0, 0, 0, 0, 0, 1, 3, 32'hBEEF_0000, 3'b101, 2'd2, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 4, 32'hBEEF_0000, 3'b001, 2'd2, 0, 0);
        idle_cyc(0);
        chk("lhu_wdata", wdata, 32'h0000_BEEF);
        idle_cyc(0);
        chk("lh_wdata", wdata, 32'hFFFF_BEEF);

        // Fill the FIFO behind continuous ALU traffic.
        cyc(1, 10, 32'hA0, 0, 0, 1, 14, 32'h1111_1111, 3'b010, 0, 0, 0);
        cyc(1, 11, 32'hA1, 0, 0, 1, 15, 32'h2222_2222, 3'b010, 0, 0, 0);
        cyc(1, 12, 32'hA2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("full_ld_ready", ld_ready, 0);
        chk("full_alu_stall", alu_stall, 1);
        cyc(1, 12, 32'hA2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("after_pop_ld_ready", ld_ready, 1);
        chk("full_head_wdata", wdata, 32'h1111_1111);
        idle_cyc(0);
        idle_cyc(0);

        // x0 writes and x0 issue.
        cyc(1, 0, 32'hDEAD, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_cyc(0);
        chk("x0_wen", wen, 0);
        chk("x0_busy", rs1_busy, 0);

        // Async reset with one buffered entry and busy[9].
        cyc(0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 9, 0);
        cyc(1, 11, 32'h55, 0, 0, 1, 12, 32'h77, 3'b010, 0, 9, 0);
        cyc(1, 13, 32'h66, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_ld_ready", ld_ready, 1);
        chk("async_rst_busy9", rs1_busy, 0);
        chk("async_rst_wen", wen, 0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        idle_cyc(9);
        idle_cyc(9);
        idle_cyc(9);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 1), 5'($urandom), $urandom,
                $urandom_range(0, 2) == 0, 5'($urandom),
                $urandom_range(0, 1), 5'($urandom), $urandom,
                3'($urandom), 2'($urandom), 5'($urandom), 5'($urandom));
        end
        idle_cyc(0);
        idle_cyc(0);
        idle_cyc(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_writeback_ctrl.md
Name: regfile_writeback_ctrl

Overview:
Drives the write port (wen/waddr/wdata) of the 32x32 register file, so it is the writer side of the register file interface.
- Merges two writeback sources: single-cycle ALU results and multi-cycle load responses.
- Load responses are extracted and sign-extended, then buffered in a small FIFO.
- A 32-entry busy scoreboard tracks destination registers of outstanding loads and exposes read-after-write hazard flags to the decode stage.

Parameters:
DEPTH, 2, load-response FIFO entries (power of two, >=2)
XLEN, 32, data width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU writeback request this cycle
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
alu_stall  out  1  ALU writeback blocked this cycle; upstream holds request
ld_issue_valid  in  1  load issued to memory this cycle
ld_issue_rd  in  5  destination of issued load
ld_valid  in  1  load response valid
ld_ready  out  1  FIFO can accept a response
ld_rd  in  5  response destination
ld_data  in  XLEN  raw memory word
ld_funct3  in  3  load type
ld_offset  in  2  byte address [1:0]
rs1  in  5  decode source 1
rs2  in  5  decode source 2
rs1_busy  out  1  rs1 has an outstanding load
rs2_busy  out  1  rs2 has an outstanding load
wen  out  1  register file write enable
waddr  out  5  register file write address
wdata  out  XLEN  register file write data

Behaviour:
- Async reset (rst_n low) clears the FIFO (count=0), the busy vector (all 0) and wen/waddr/wdata (0).
  - Reset outputs: ld_ready=1, alu_stall=0, rs*_busy=0.
  - Reset mid-operation discards buffered responses and pending busy bits.
- Load extraction at push. Byte lane is ld_data[8*off+:8]; halfword is ld_data[16*off[1]+:16].
  - 000 LB: sign-extend the byte lane.
  - 001 LH: sign-extend the halfword.
  - 010 LW: full word.
  - 100 LBU: zero-extend the byte lane.
  - 101 LHU: zero-extend the halfword.
  - Any other funct3: raw word.
  - Misaligned halfword (off=3) uses off[1]; no trap.
- FIFO handshake:
  - Push when ld_valid & ld_ready.
  - ld_ready = (count < DEPTH), combinational from count only.
  - When full, ld_ready=0 even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
- Write arbitration each cycle (the selection is combinational):
  - If count==DEPTH: FIFO head wins; alu_stall=1 and the ALU request is ignored.
  - Else if alu_valid: ALU wins; alu_stall=0.
  - Else if count>0: FIFO head is popped.
  - A response pushed in cycle N is eligible for pop at cycle N+1 at the earliest (no same-cycle bypass).
- Output register: the selected write appears on wen/waddr/wdata one cycle after selection.
  - ALU request at cycle N -> wen=1 at N+1.
  - Write to rd=0 produces wen=0. waddr/wdata may still update, but wen must stay 0.
  - No selection -> wen=0.
- Scoreboard:
  - Set: ld_issue_valid & ld_issue_rd!=0 sets busy[ld_issue_rd].
  - Clear: popping a FIFO entry clears busy[entry rd], in the pop cycle.
  - Same-cycle set and clear of the same rd: set wins.
  - Busy for x0 is never set.
- Hazard flags: rs1_busy = busy[rs1], rs2_busy = busy[rs2], combinational.
  - A register cleared in cycle N reads not-busy at N+1; its value is in the register file at N+2 (decode stalls or forwards).
- ALU writes never touch the busy vector. Decode is responsible for not issuing an ALU op whose rd is busy, so no WAW hazard occurs.

Decomposition:
- Shared package: LOAD_* funct3 constants (LB, LH, LW, LBU, LHU), REG_X0 constant, a wb_entry_t struct {rd[4:0], data[XLEN-1:0]}.
- One sub-module: wb_fifo, a parameterised synchronous FIFO of wb_entry_t with count, push/pop, and an async active-low reset.
- Extraction logic and the scoreboard stay inline.

Test Plan:
- Reset, then alu_valid=1, rd=5, data=0x1234 at cycle N -> wen=1, waddr=5, wdata=0x1234 at N+1; following cycle wen=0.
- ld_issue rd=7; response LB, data=0x0000_80FF, off=1 -> rs1_busy=1 while rs1=7 until pop; write wdata=0xFFFF_FF80; rs1_busy=0 the cycle after pop.
- LHU, data=0xBEEF_0000, off=2 -> 0x0000_BEEF. LH, same data -> 0xFFFF_BEEF.
- ALU valid every cycle while two responses arrive -> FIFO fills (ld_ready=0); next cycle alu_stall=1 and the FIFO head writes; after a pop, ld_ready=1.
- ALU rd=0, data=0xDEAD -> wen stays 0. ld_issue rd=0 -> rs1_busy=0 for rs1=0.
- Deassert rst_n with one FIFO entry and busy[9] set -> asynchronously count=0, busy[9]=0, wen=0, ld_ready=1; no write after release.
